multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: IR[31:26], stable from DECODE until the next FETCH.
REQ-004 SHALL have port funct, input, 6 bits: IR[5:0].
REQ-005 SHALL have port instr_zero, input, 1 bit: IR is all zeros (end-of-program).
REQ-006 SHALL have port alu_zero, input, 1 bit: ALU zero output.
REQ-007 SHALL have port alu_neg, input, 1 bit: ALU sign output.
REQ-008 SHALL have port mem_ready, input, 1 bit: shared memory completes the current access this cycle.
REQ-009 SHALL have outputs pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, 1 bit each: datapath strobes and mux selects.
REQ-010 SHALL have outputs alu_src_b, alu_op, reg_dst, pc_src, 2 bits each.
  - alu_src_b: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
  - reg_dst: 00 rt, 01 rd, 10 r31.
  - pc_src: 00 ALU, 01 target register, 10 jump address, 11 rs.
REQ-011 SHALL have outputs halted and illegal, 1 bit each, plus state, 3 bits, and retired, 16 bits.

Function
REQ-012 SHALL use one-hot-free encoded states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with illegal=1.
REQ-013 SHALL drive every strobe not listed for a state to 0 in that state.
REQ-014 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-015 In FETCH, ir_write and pc_write SHALL equal mem_ready; the block SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-017 DECODE SHALL branch as follows:
  - instr_zero=1 -> HALT.
  - opcode 0x00 (R), 0x23 (lw), 0x2B (sw), 0x04 (beq) -> EXEC.
  - opcode 0x02 (j) -> pc_write=1, pc_src=10, then FETCH.
  - any other opcode -> HALT with illegal=1.
REQ-018 EXEC behaviour by instruction class:
  - Plain R-type: alu_src_a=1, alu_src_b=00, alu_op=10, next state WB.
  - lw/sw: alu_src_a=1, alu_src_b=10, alu_op=00, next state MEM.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, next state FETCH.
REQ-019 R-type funct 0x14 (brz) in EXEC SHALL drive pc_src=11 with pc_write=z_flag, then go to FETCH.
REQ-020 R-type funct 0x17 (balrn) in EXEC SHALL behave as follows:
  - n_flag=1: pc_write=1, pc_src=11, next state WB.
  - n_flag=0: next state FETCH.
REQ-021 MEM SHALL drive iord=1, with mem_read=1 for lw and mem_write=1 for sw.
REQ-022 MEM SHALL hold until mem_ready=1; it SHALL then go to WB for lw and to FETCH for sw.
REQ-023 WB behaviour by instruction class:
  - R-type: reg_write=1, reg_dst=01, mem_to_reg=0.
  - lw: reg_write=1, reg_dst=00, mem_to_reg=1.
  - balrn: reg_write=1, reg_dst=10, link write of PC+4.
  - Next state SHALL be FETCH in all cases.
REQ-024 z_flag and n_flag SHALL be internal registers loaded from alu_zero/alu_neg on the clock edge leaving WB of a plain R-type; all other instructions SHALL hold them.
REQ-025 retired SHALL increment by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB; it SHALL wrap 0xFFFF->0x0000.
REQ-026 HALT SHALL drive halted=1 with all strobes 0 and SHALL remain in HALT until reset; illegal SHALL stay latched.
REQ-027 Latency SHALL be as follows, with each mem_ready=0 cycle in FETCH/MEM adding one cycle:
  - j: 2 cycles.
  - beq, brz, balrn not taken: 3 cycles.
  - R-type, sw, balrn taken: 4 cycles.
  - lw: 5 cycles.

Reset
REQ-028 While rst_n=0, the block SHALL force state=FETCH, all strobes 0, z_flag=n_flag=0, retired=0, halted=0, illegal=0, immediately and independent of clk.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further pc_write/reg_write/mem_write; after release, the first edge SHALL begin a fresh FETCH.

Verification
REQ-030 R-type (opcode 0x00, funct 0x20), mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB; retired 0->1.
REQ-031 lw with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, mem_read=iord=1 throughout, WB mem_to_reg=1; total 7 cycles.
REQ-032 R-type with alu_neg=1, then balrn -> pc_write=1 with pc_src=11 in EXEC, then WB reg_dst=10; with n_flag=0, balrn takes 3 cycles and causes no reg_write.
REQ-033 instr_zero=1 at DECODE -> HALT, halted=1, strobes 0 for 10+ cycles; opcode 0x3F -> HALT with illegal=1.
REQ-034 rst_n pulled low in MEM of sw mid-cycle -> mem_write drops immediately, state=0, retired=0; normal fetch resumes after release.
REQ-035 Preload retired=0xFFFF via 65535 j instructions -> next retirement gives 0x0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and mux selects, keeps the brz/balrn condition
// flags, and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        instr_zero,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  pc_src,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_BRZ   = 6'h14;
  localparam logic [5:0] FN_BALRN = 6'h17;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        z_flag_q, z_flag_d;
  logic        n_flag_q, n_flag_d;
  logic [15:0] retired_q, retired_d;

  logic is_rtype, is_lw, is_sw, is_beq, is_j, is_brz, is_balrn, is_plain_r;
  logic enter_fetch;

  // Instruction class decode; IR is held stable from DECODE to the next FETCH,
  // so later states can decode it again instead of storing a class register.
  always_comb begin
    is_rtype   = (opcode == OP_RTYPE);
    is_lw      = (opcode == OP_LW);
    is_sw      = (opcode == OP_SW);
    is_beq     = (opcode == OP_BEQ);
    is_j       = (opcode == OP_J);
    is_brz     = is_rtype && (funct == FN_BRZ);
    is_balrn   = is_rtype && (funct == FN_BALRN);
    is_plain_r = is_rtype && !is_brz && !is_balrn;
  end

  // Next-state, flag and retirement-counter computation.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    z_flag_d    = z_flag_q;
    n_flag_d    = n_flag_q;
    enter_fetch = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (instr_zero) begin
          state_d = S_HALT;
        end else if (is_rtype || is_lw || is_sw || is_beq) begin
          state_d = S_EXEC;
        end else if (is_j) begin
          state_d     = S_FETCH;
          enter_fetch = 1'b1;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_brz || (is_balrn && !n_flag_q)) begin
          state_d     = S_FETCH;
          enter_fetch = 1'b1;
        end else if (is_balrn || is_plain_r) begin
          state_d = S_WB;
        end else begin
          // IR changed underneath us; treat as an illegal instruction.
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d     = S_FETCH;
            enter_fetch = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d     = S_FETCH;
        enter_fetch = 1'b1;
        if (is_plain_r) begin
          z_flag_d = alu_zero;
          n_flag_d = alu_neg;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
    retired_d = enter_fetch ? (retired_q + 16'd1) : retired_q;
  end

  // State machine and architectural flags, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      z_flag_q  <= 1'b0;
      n_flag_q  <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      z_flag_q  <= z_flag_d;
      n_flag_q  <= n_flag_d;
      retired_q <= retired_d;
    end
  end

  // Strobe decode. FETCH strobes follow mem_ready within the cycle, so these
  // cannot be registered; reset gates them off immediately.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 2'b00;
    pc_src        = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (!instr_zero && is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end else if (is_beq) begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end else if (is_brz) begin
          pc_src   = 2'b11;
          pc_write = z_flag_q;
        end else if (is_balrn) begin
          if (n_flag_q) begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
          end
        end else if (is_plain_r) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_lw) begin
          mem_to_reg = 1'b1;
        end else if (is_balrn) begin
          reg_dst = 2'b10;
        end else begin
          reg_dst = 2'b01;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_dst       = 2'b00;
      pc_src        = 2'b00;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle strobe trace; a compare process
// checks every cycle, plus literal checks on key points.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        instr_zero, alu_zero, alu_neg, mem_ready;
  logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic        reg_write, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, reg_dst, pc_src;
  logic        halted, illegal;
  logic [2:0]  state;
  logic [15:0] retired;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .instr_zero(instr_zero), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .pc_src(pc_src),
    .halted(halted), .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, pcwc, irw, iord, mrd, mwr, rw, m2r, asa;
    logic [1:0]  asb, aop, rdst, psrc;
    logic        hlt, ill;
    logic [15:0] ret;
  } rec_t;

  rec_t exp_q[$];
  rec_t cmp_e, cmp_a;
  int   checks = 0;
  int   errors = 0;

  // Instruction-level model state
  logic [15:0] m_ret;
  logic        m_z, m_n, m_ill;

  // Per-cycle comparison against the expected trace
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_a = {state, pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, reg_dst, pc_src,
               halted, illegal, retired};
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL cycle_trace t=%0t actual=%h required=%h", $time, cmp_a, cmp_e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic rec_t base(input logic [2:0] st);
    rec_t r;
    r     = '0;
    r.st  = st;
    r.hlt = (st == 3'd5);
    r.ill = m_ill;
    r.ret = m_ret;
    return r;
  endfunction

  // Queue the expectation for the current cycle and advance one cycle.
  task automatic emit(input rec_t r);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ret = 16'd0; m_z = 1'b0; m_n = 1'b0; m_ill = 1'b0;
  endtask

  // Execute one instruction: fw/mw are wait cycles in FETCH/MEM.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic iz,
                           input int fw, input int mw, input logic az, input logic an,
                           input logic abort_mem);
    rec_t r;
    logic rt, brz, balrn, plain;
    opcode = op; funct = fn; instr_zero = iz; alu_zero = az; alu_neg = an;
    rt    = (op == 6'h00);
    brz   = rt && (fn == 6'h14);
    balrn = rt && (fn == 6'h17);
    plain = rt && !brz && !balrn;
    for (int w = 0; w <= fw; w++) begin
      mem_ready = (w == fw);
      r = base(3'd0); r.mrd = 1'b1; r.asb = 2'b01; r.irw = mem_ready; r.pcw = mem_ready;
      emit(r);
    end
    mem_ready = 1'b0;
    r = base(3'd1); r.asb = 2'b11;
    if (iz) begin emit(r); return; end
    if (op == 6'h02) begin
      r.pcw = 1'b1; r.psrc = 2'b10; emit(r); m_ret = m_ret + 16'd1; return;
    end
    if (!(rt || op == 6'h23 || op == 6'h2B || op == 6'h04)) begin
      emit(r); m_ill = 1'b1; return;
    end
    emit(r);
    r = base(3'd2);
    if (op == 6'h23 || op == 6'h2B) begin
      r.asa = 1'b1; r.asb = 2'b10; emit(r);
      for (int w = 0; w <= mw; w++) begin
        mem_ready = (w == mw);
        r = base(3'd3); r.iord = 1'b1; r.mrd = (op == 6'h23); r.mwr = (op == 6'h2B);
        if (abort_mem) begin
          mem_ready = 1'b0;
          exp_q.push_back(r);
          @(negedge clk);
          #2 rst_n = 1'b0;
          #1;
          chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
          chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
          chk("abort_state", {29'd0, state}, 32'd0);
          chk("abort_retired", {16'd0, retired}, 32'd0);
          model_reset();
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
        emit(r);
      end
      mem_ready = 1'b0;
      if (op == 6'h2B) begin m_ret = m_ret + 16'd1; return; end
      r = base(3'd4); r.rw = 1'b1; r.m2r = 1'b1; emit(r);
      m_ret = m_ret + 16'd1;
      return;
    end
    if (op == 6'h04) begin
      r.asa = 1'b1; r.aop = 2'b01; r.pcwc = 1'b1; r.psrc = 2'b01; emit(r);
      m_ret = m_ret + 16'd1; return;
    end
    if (brz) begin
      r.psrc = 2'b11; r.pcw = m_z; emit(r); m_ret = m_ret + 16'd1; return;
    end
    if (balrn) begin
      if (!m_n) begin emit(r); m_ret = m_ret + 16'd1; return; end
      r.pcw = 1'b1; r.psrc = 2'b11; emit(r);
      r = base(3'd4); r.rw = 1'b1; r.rdst = 2'b10; emit(r);
      m_ret = m_ret + 16'd1; return;
    end
    if (plain) begin
      r.asa = 1'b1; r.aop = 2'b10; emit(r);
      r = base(3'd4); r.rw = 1'b1; r.rdst = 2'b01; emit(r);
      m_z = az; m_n = an;
      m_ret = m_ret + 16'd1;
    end
  endtask

  task automatic run_halt(input int n);
    for (int i = 0; i < n; i++) emit(base(3'd5));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_strobe_mem_read", {31'd0, mem_read}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; instr_zero = 1'b0;
    alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_pc_write", {31'd0, pc_write}, 32'd0);
    chk("reset_retired", {16'd0, retired}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R-type add, leaves n_flag=1
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("rtype_retired", {16'd0, retired}, 32'd1);
    // lw: one FETCH wait, two MEM waits
    run_instr(6'h23, 6'h00, 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    chk("lw_retired", {16'd0, retired}, 32'd2);
    // balrn taken (n=1)
    run_instr(6'h00, 6'h17, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    // R-type setting z=1, n=0
    run_instr(6'h00, 6'h22, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(6'h00, 6'h14, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);  // brz taken
    run_instr(6'h00, 6'h17, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);  // balrn not taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);  // beq
    run_instr(6'h2B, 6'h00, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);  // sw
    run_instr(6'h02, 6'h00, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);  // j
    run_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);  // R-type z=0
    run_instr(6'h00, 6'h14, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);  // brz not taken
    chk("mix_retired", {16'd0, retired}, 32'd11);

    // sw aborted by reset in MEM, then normal fetch
    run_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1'b0, 1'b0, 1'b1);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("post_abort_retired", {16'd0, retired}, 32'd1);

    // Counter wrap: preload 0xFFFF, one j retires to 0x0000
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    m_ret = 16'hFFFF;
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap_retired", {16'd0, retired}, 32'd0);

    // End of program
    run_instr(6'h00, 6'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_halt(12);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_illegal", {31'd0, illegal}, 32'd0);

    // Illegal opcode
    do_reset();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_halt(3);
    chk("illegal_flag", {31'd0, illegal}, 32'd1);
    chk("illegal_state", {29'd0, state}, 32'd5);
    do_reset();
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("final_retired", {16'd0, retired}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
